// File: rtl/output_classifier_if.sv
// Request/result bus between the output_classifier and its consumer (command/LED decoding).
//
// Handshake: start is a one-cycle request that is only honoured while the classifier is idle.
// There is no ready signal and no queueing, so a requester must watch busy.
// result_valid is a one-cycle pulse, and class_id/max_score/confident hold until the next pulse.
interface output_classifier_if #(
  parameter int NUM_CLASSES = 4,
  parameter int SCORE_W     = 60,
  parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
);
  logic                      start;
  logic signed [SCORE_W-1:0] scores_in [NUM_CLASSES];
  logic                      busy;
  logic                      result_valid;
  logic [IDX_W-1:0]          class_id;
  logic signed [SCORE_W-1:0] max_score;
  logic                      confident;

  modport master (
    output start, scores_in,
    input  busy, result_valid, class_id, max_score, confident
  );

  modport slave (
    input  start, scores_in,
    output busy, result_valid, class_id, max_score, confident
  );
endinterface

// File: rtl/output_classifier.sv
// Sequential arg-max over the final dense layer scores. It scans a snapshot one score per cycle and
// reports the winning class, its score, and whether it leads the runner-up by at least MARGIN.
module output_classifier #(
  parameter int                 NUM_CLASSES = 4,
  parameter int                 SCORE_W     = 60,
  parameter int                 IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  parameter logic [SCORE_W-1:0] MARGIN      = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [1:0]         dbg_state,
  output_classifier_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [SCORE_W-1:0] MOST_NEG   = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]          LAST_IDX   = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [SCORE_W:0]   MARGIN_EXT = {1'b0, MARGIN};

  state_t                    state_q, state_d;
  logic signed [SCORE_W-1:0] snap_q [NUM_CLASSES];
  logic signed [SCORE_W-1:0] best_q, runner_q, cur_score;
  logic [IDX_W-1:0]          best_idx_q, idx_q;
  logic signed [SCORE_W:0]   lead;
  logic                      lead_ok;

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Index-compare mux keeps the snapshot select clean when NUM_CLASSES is not a power of two.
  always_comb begin
    cur_score = snap_q[0];
    for (int k = 1; k < NUM_CLASSES; k++) begin
      if (idx_q == IDX_W'(k)) cur_score = snap_q[k];
    end
  end

  // One extra bit keeps the lead from overflowing, even against a most-negative runner-up.
  assign lead    = {best_q[SCORE_W-1], best_q} - {runner_q[SCORE_W-1], runner_q};
  assign lead_ok = (NUM_CLASSES == 1) ? 1'b1 : (lead >= MARGIN_EXT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CLASSES; k++) snap_q[k] <= '0;
      best_q           <= '0;
      runner_q         <= '0;
      best_idx_q       <= '0;
      idx_q            <= '0;
      bus.busy         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.class_id     <= '0;
      bus.max_score    <= '0;
      bus.confident    <= 1'b0;
    end else begin
      bus.result_valid <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          bus.busy <= bus.start;
          if (bus.start) begin
            snap_q     <= bus.scores_in;
            best_q     <= MOST_NEG;
            runner_q   <= MOST_NEG;
            best_idx_q <= '0;
            idx_q      <= '0;
          end
        end
        SCAN: begin
          // Strict compares: on a tie the earlier index keeps the win.
          if (cur_score > best_q) begin
            runner_q   <= best_q;
            best_q     <= cur_score;
            best_idx_q <= idx_q;
          end else if (cur_score > runner_q) begin
            runner_q <= cur_score;
          end
          idx_q <= idx_q + 1'b1;
        end
        DONE: begin
          bus.class_id  <= best_idx_q;
          bus.max_score <= best_q;
          bus.confident <= lead_ok;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/output_classifier.md
# output_classifier

Sequential arg-max stage that sits directly downstream of the final dense layer. On `start` it snapshots the ReLU'd class scores and scans them one per cycle, tracking the best and runner-up. It then reports the winning class index, its score, and a confidence flag based on a programmable winner margin. The result drives the command/LED decoding logic of the speech recogniser.

## Interface
Parameters:
- NUM_CLASSES, OUT_SIZE_3: number of class scores; must be ≥ 1.
- SCORE_W, 60: signed score width, matching the final layer output.
- IDX_W, $clog2(NUM_CLASSES) (minimum 1): width of `class_id`.
- MARGIN, 0: minimum required lead (best − runner-up) for `confident`; non-negative, SCORE_W-bit.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle request; samples `scores_in`.
- scores_in, input, signed [SCORE_W-1:0] × NUM_CLASSES: class scores from the final dense layer.
- busy, output, 1: high from the cycle after `start` is accepted until `result_valid` drops.
- result_valid, output, 1: one-cycle pulse when the result fields are updated.
- class_id, output, IDX_W: index of the highest score.
- max_score, output, signed [SCORE_W-1:0]: the highest score.
- confident, output, 1: 1 when best − runner-up ≥ MARGIN.

## Operation
- FSM with states IDLE → SCAN → DONE → IDLE.
- IDLE:
  - When `start`=1: copy all `scores_in` into an internal snapshot.
  - Set best = runner-up = most-negative SCORE_W value, best_idx = 0, i = 0.
  - Go to SCAN.
  - `start`=0: stay in IDLE.
- SCAN: one snapshot element s = snap[i] is compared per cycle.
  - If s > best: runner-up ← best, best ← s, best_idx ← i.
  - Else if s > runner-up: runner-up ← s.
  - i increments; after i = NUM_CLASSES−1 is processed, go to DONE.
- Ties: the comparison is strict, so the lowest index wins. An equal later score updates only the runner-up.
- DONE:
  - Register class_id ← best_idx and max_score ← best.
  - Register confident ← ((best − runner-up), computed at SCORE_W+1 bits signed) ≥ MARGIN.
  - Pulse `result_valid`, then return to IDLE.
- NUM_CLASSES = 1: the runner-up stays most-negative. The SCORE_W+1-bit difference must not overflow; `confident`=1 for any MARGIN.
- `start` while not IDLE: ignored, with no queueing. `scores_in` may change freely after acceptance because the snapshot is used.
- Result outputs hold their last value until the next DONE.

## Timing
- Reset (rst=0, asynchronous):
  - State IDLE; `busy`=0, `result_valid`=0, `class_id`=0, `max_score`=0, `confident`=0.
  - Snapshot and trackers are cleared.
- Reset mid-scan aborts immediately, with no `result_valid`. `start` is accepted on the first edge after rst deasserts.
- Latency: with `start` sampled at edge E0, SCAN covers edges E1..EN (N = NUM_CLASSES).
  - DONE registers the outputs at E(N+1).
  - `result_valid` is high for exactly the cycle between E(N+1) and E(N+2).
- `busy` is high from E0 through E(N+2), and is low in the cycle `result_valid` drops.
- Back-to-back: `start` held high continuously is accepted again on the edge where the state is IDLE. Throughput is one classification per N+2 cycles.
- The MARGIN comparison is unsigned-safe: the difference is always ≥ 0, except in the NUM_CLASSES=1 case above.

## Test plan
- Reset: assert rst=0 mid-SCAN with N=4 → all outputs 0 immediately; no `result_valid` afterwards until a new `start`.
- Basic arg-max, N=4, scores {10, 250, 30, 7}, MARGIN=0, `start` at E0 → `result_valid` at E5, `class_id`=1, `max_score`=250, `confident`=1.
- Tie: scores {5, 90, 90, 1}, MARGIN=0 → `class_id`=1, `max_score`=90. Difference 0 ≥ 0, so `confident`=1; the same stimulus with MARGIN=1 gives `confident`=0.
- Margin: scores {100, 60, 0, 0}, MARGIN=50 → `class_id`=0, `confident`=0; the same with MARGIN=40 → `confident`=1.
- Snapshot and ignore: change `scores_in` to {0, 0, 0, 999} one cycle after `start`, and pulse `start` again during SCAN → result reflects the original scores; exactly one `result_valid` pulse.
- Extremes: scores {−2^59, 2^59−1, 0, 0} and all-zero input → `class_id`=1 with a correct `confident` and no overflow. All-zero input gives `class_id`=0, `max_score`=0, `confident`=1 when MARGIN=0.
